// File: rtl/ar_channel_arbiter.sv
// Two-master AXI read-address arbiter: round-robin grant, per-master outstanding limit, registered request toward the decoder.
// Optional build macro AR_QOS_PRIORITY_EN: the eligible master with strictly higher arqos wins, ties fall back to round-robin.
module ar_channel_arbiter #(
    parameter int Masters_ID_Size = 1,
    parameter int Address_width   = 32,
    parameter int AXI4_AR_len     = 8,
    parameter int Max_Outstanding = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       S0_AXI_arvalid,
    input  logic [3:0]                 S0_AXI_arqos,
    input  logic [Address_width-1:0]   S0_AXI_araddr,
    input  logic [AXI4_AR_len-1:0]     S0_AXI_arlen,
    input  logic [2:0]                 S0_AXI_arsize,
    input  logic [1:0]                 S0_AXI_arburst,
    output logic                       S0_AXI_arready,
    input  logic                       S1_AXI_arvalid,
    input  logic [3:0]                 S1_AXI_arqos,
    input  logic [Address_width-1:0]   S1_AXI_araddr,
    input  logic [AXI4_AR_len-1:0]     S1_AXI_arlen,
    input  logic [2:0]                 S1_AXI_arsize,
    input  logic [1:0]                 S1_AXI_arburst,
    output logic                       S1_AXI_arready,
    output logic [Masters_ID_Size-1:0] Master_AXI_araddr_ID,
    output logic [Address_width-1:0]   Master_AXI_araddr,
    output logic [AXI4_AR_len-1:0]     Master_AXI_arlen,
    output logic [2:0]                 Master_AXI_arsize,
    output logic [1:0]                 Master_AXI_arburst,
    output logic                       Master_AXI_arvalid,
    input  logic                       Sel_Slave_Ready,
    input  logic                       R_Done,
    input  logic [Masters_ID_Size-1:0] R_Done_ID,
    output logic                       Err_Underflow,
    output logic                       fsm_state
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [3:0] MAX_OUT = 4'(Max_Outstanding);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a master-side grant is only offered in IDLE, and the request is held unchanged in SEND until Sel_Slave_Ready.
    state_t          state;
    logic            last_grant;
    logic            sel_id;
    logic [1:0][3:0] outstanding;
    logic [1:0]      underflow;
    logic            elig0, elig1, win1, grant0, grant1;

    assign elig0 = S0_AXI_arvalid && (outstanding[0] < MAX_OUT);
    assign elig1 = S1_AXI_arvalid && (outstanding[1] < MAX_OUT);

`ifdef AR_QOS_PRIORITY_EN
    always_comb begin
        win1 = elig1;
        if (elig0 && elig1) begin
            if (S1_AXI_arqos > S0_AXI_arqos)      win1 = 1'b1;
            else if (S0_AXI_arqos > S1_AXI_arqos) win1 = 1'b0;
            else                                  win1 = !last_grant;
        end
    end
`else
    logic unused_qos;
    assign unused_qos = ^{S0_AXI_arqos, S1_AXI_arqos};
    // M1 wins when it is the only eligible master or when M0 was granted last.
    assign win1 = elig1 && (!elig0 || !last_grant);
`endif

    assign grant0         = (state == IDLE) && elig0 && !win1;
    assign grant1         = (state == IDLE) && elig1 && win1;
    assign S0_AXI_arready = grant0;
    assign S1_AXI_arready = grant1;
    assign fsm_state      = state;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state                <= IDLE;
            last_grant           <= 1'b1;
            sel_id               <= 1'b0;
            Master_AXI_araddr_ID <= '0;
            Master_AXI_araddr    <= '0;
            Master_AXI_arlen     <= '0;
            Master_AXI_arsize    <= '0;
            Master_AXI_arburst   <= '0;
            Master_AXI_arvalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        sel_id               <= grant1;
                        Master_AXI_araddr_ID <= Masters_ID_Size'(grant1);
                        Master_AXI_araddr    <= grant1 ? S1_AXI_araddr  : S0_AXI_araddr;
                        Master_AXI_arlen     <= grant1 ? S1_AXI_arlen   : S0_AXI_arlen;
                        Master_AXI_arsize    <= grant1 ? S1_AXI_arsize  : S0_AXI_arsize;
                        Master_AXI_arburst   <= grant1 ? S1_AXI_arburst : S0_AXI_arburst;
                        Master_AXI_arvalid   <= 1'b1;
                        state                <= SEND;
                    end
                end
                SEND: begin
                    if (Sel_Slave_Ready) begin
                        Master_AXI_arvalid <= 1'b0;
                        last_grant         <= sel_id;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_cnt
        logic       inc, dec;
        logic [3:0] cnt;

        assign inc            = (state == SEND) && Sel_Slave_Ready && (sel_id == 1'(k));
        assign dec            = R_Done && (R_Done_ID == Masters_ID_Size'(k));
        assign underflow[k]   = dec && (cnt == 4'd0);
        assign outstanding[k] = cnt;

        // A simultaneous accept and completion on one master cancels out.
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN)                         cnt <= 4'd0;
            else if (inc && !dec)                 cnt <= cnt + 4'd1;
            else if (dec && !inc && cnt != 4'd0)  cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)        Err_Underflow <= 1'b0;
        else if (|underflow) Err_Underflow <= 1'b1;
    end

endmodule

// File: tb/tb_ar_channel_arbiter.sv
// Self-checking bench for ar_channel_arbiter: per-scenario tasks plus a scoreboard monitor on the decoder-side handshake.
module tb_ar_channel_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_arvalid, s1_arvalid;
  logic [3:0]  s0_arqos, s1_arqos;
  logic [31:0] m0_addr, m1_addr;
  logic [7:0]  m0_len, m1_len;
  logic [2:0]  m0_size, m1_size;
  logic [1:0]  m0_burst, m1_burst;
  logic        s0_arready, s1_arready;
  logic [0:0]  out_id;
  logic [31:0] out_addr;
  logic [7:0]  out_len;
  logic [2:0]  out_size;
  logic [1:0]  out_burst;
  logic        out_valid;
  logic        sel_ready;
  logic        r_done;
  logic [0:0]  r_done_id;
  logic        err_underflow;
  logic        fsm_state;

  logic [45:0] exp_q[$];
  int          model_cnt[2];
  int          n_checks;
  int          n_fail;

  ar_channel_arbiter dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S0_AXI_arvalid(s0_arvalid), .S0_AXI_arqos(s0_arqos), .S0_AXI_araddr(m0_addr),
    .S0_AXI_arlen(m0_len), .S0_AXI_arsize(m0_size), .S0_AXI_arburst(m0_burst),
    .S0_AXI_arready(s0_arready),
    .S1_AXI_arvalid(s1_arvalid), .S1_AXI_arqos(s1_arqos), .S1_AXI_araddr(m1_addr),
    .S1_AXI_arlen(m1_len), .S1_AXI_arsize(m1_size), .S1_AXI_arburst(m1_burst),
    .S1_AXI_arready(s1_arready),
    .Master_AXI_araddr_ID(out_id), .Master_AXI_araddr(out_addr), .Master_AXI_arlen(out_len),
    .Master_AXI_arsize(out_size), .Master_AXI_arburst(out_burst), .Master_AXI_arvalid(out_valid),
    .Sel_Slave_Ready(sel_ready), .R_Done(r_done), .R_Done_ID(r_done_id),
    .Err_Underflow(err_underflow), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [45:0] exp_item(input int k);
    if (k == 0) return {1'b0, m0_addr, m0_len, m0_size, m0_burst};
    else        return {1'b1, m1_addr, m1_len, m1_size, m1_burst};
  endfunction

  // Scoreboard: every decoder-side handshake must match the oldest expected grant.
  always @(negedge clk) begin
    logic [45:0] got, exp;
    if (rst_n && out_valid && sel_ready) begin
      n_checks++;
      got = {out_id, out_addr, out_len, out_size, out_burst};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_grant: got %h, none expected", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL grant_payload: got %h expected %h", got, exp);
        end
        model_cnt[int'(exp[45])]++;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_payload();
    m0_addr = $urandom(); m0_len = 8'($urandom_range(0, 255));
    m0_size = 3'($urandom_range(0, 7)); m0_burst = 2'($urandom_range(0, 2));
    m1_addr = $urandom(); m1_len = 8'($urandom_range(0, 255));
    m1_size = 3'($urandom_range(0, 7)); m1_burst = 2'($urandom_range(0, 2));
  endtask

  task automatic set_valid(input int k, input logic v);
    if (k == 0) s0_arvalid = v;
    else        s1_arvalid = v;
  endtask

  task automatic run_grants(input int k, input int n);
    int waited;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_item(k));
    set_valid(k, 1'b1);
    for (int i = 0; i < n; i++) begin
      waited = 0;
      @(negedge clk);
      while (!(k == 0 ? s0_arready : s1_arready) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (waited >= 50) begin
        n_fail++;
        $display("FAIL grant_timeout: master %0d request %0d got no arready, required 1", k, i);
      end
      @(negedge clk);
    end
    tick();
    set_valid(k, 1'b0);
  endtask

  task automatic drain();
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      while (model_cnt[k] > 0) begin
        r_done = 1'b1;
        r_done_id = 1'(k);
        model_cnt[k]--;
        tick();
      end
    end
    r_done = 1'b0;
    r_done_id = 1'b0;
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_id, out_addr, out_len, out_size, out_burst} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b addr=%h, required all zero", out_valid, out_addr);
    end
    n_checks++;
    if ({err_underflow, fsm_state, s1_arready, s0_arready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 0000", {err_underflow, fsm_state, s1_arready, s0_arready});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    randomize_payload();
    sel_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_item(i % 2));
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++;
      if ({out_valid, s1_arready, s0_arready} !== {1'b0, exp_rdy}) begin
        n_fail++;
        $display("FAIL rr_idle_%0d: got valid/ready %b required %b", i, {out_valid, s1_arready, s0_arready}, {1'b0, exp_rdy});
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid, s1_arready, s0_arready} !== 3'b100) begin
        n_fail++;
        $display("FAIL rr_send_%0d: got valid/ready %b required 100", i, {out_valid, s1_arready, s0_arready});
      end
    end
    tick();
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    m0_addr = 32'h4000_0010;
    sel_ready = 1'b1;
    exp_q.push_back(exp_item(0));
    s0_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s0_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_grant: got s0_arready %b required 1", s0_arready);
    end
    tick();
    sel_ready = 1'b0;
    s1_arvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel_ready = (i == 5);
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_id, out_addr, s1_arready, s0_arready} !== {1'b1, 1'b0, 32'h4000_0010, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%b id=%b addr=%h ready=%b required 1 0 40000010 00",
                 i, out_valid, out_id, out_addr, {s1_arready, s0_arready});
      end
      tick();
    end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    sel_ready = 1'b1;
    drain();
  endtask

  task automatic test_outstanding_limit();
    randomize_payload();
    sel_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_item(0));
    s0_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s1_arready, s0_arready} !== 2'b01) begin
        n_fail++;
        $display("FAIL limit_grant_%0d: got ready %b required 01", i, {s1_arready, s0_arready});
      end
      @(negedge clk);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, s1_arready, s0_arready} !== 3'b000) begin
        n_fail++;
        $display("FAIL limit_stall_%0d: got valid/ready %b required 000", i, {out_valid, s1_arready, s0_arready});
      end
    end
    tick();
    exp_q.push_back(exp_item(1));
    s1_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b10) begin
      n_fail++;
      $display("FAIL limit_other_master: got ready %b required 10", {s1_arready, s0_arready});
    end
    tick();
    s1_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b00) begin
      n_fail++;
      $display("FAIL limit_still_full: got ready %b required 00", {s1_arready, s0_arready});
    end
    tick();
    r_done = 1'b1;
    r_done_id = 1'b0;
    model_cnt[0]--;
    exp_q.push_back(exp_item(0));
    tick();
    r_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL limit_release: got ready %b required 01", {s1_arready, s0_arready});
    end
    tick();
    s0_arvalid = 1'b0;
    drain();
  endtask

  task automatic test_underflow();
    @(negedge clk);
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_before: got %b required 0", err_underflow);
    end
    tick();
    r_done = 1'b1;
    r_done_id = 1'b1;
    tick();
    r_done = 1'b0;
    r_done_id = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (err_underflow !== 1'b1) begin
        n_fail++;
        $display("FAIL underflow_sticky: got %b required 1", err_underflow);
      end
    end
    tick();
    randomize_payload();
    run_grants(1, 4);
    drain();
  endtask

  task automatic test_reset_in_send();
    randomize_payload();
    sel_ready = 1'b1;
    run_grants(0, 1);
    sel_ready = 1'b0;
    s1_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_setup_grant: got ready %b required 10", {s1_arready, s0_arready});
    end
    tick();
    s1_arvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_id} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_setup_send: got valid/id %b required 11", {out_valid, out_id});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_id, out_addr, err_underflow, fsm_state} !== 36'd0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got valid=%b id=%b addr=%h err=%b state=%b required all zero",
               out_valid, out_id, out_addr, err_underflow, fsm_state);
    end
    tick();
    rst_n = 1'b1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    sel_ready = 1'b1;
    exp_q.push_back(exp_item(0));
    exp_q.push_back(exp_item(1));
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_first_grant: got ready %b required 01", {s1_arready, s0_arready});
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({s1_arready, s0_arready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_second_grant: got ready %b required 10", {s1_arready, s0_arready});
    end
    tick();
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    repeat (2) tick();
    run_grants(0, 3);
    drain();
  endtask

`ifdef AR_QOS_PRIORITY_EN
  task automatic test_qos();
    randomize_payload();
    sel_ready = 1'b1;
    s0_arqos = 4'd2;
    s1_arqos = 4'd9;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_item(1));
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s1_arready, s0_arready} !== 2'b10) begin
        n_fail++;
        $display("FAIL qos_high_%0d: got ready %b required 10", i, {s1_arready, s0_arready});
      end
      @(negedge clk);
    end
    tick();
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    drain();
    s0_arqos = 4'd5;
    s1_arqos = 4'd5;
    exp_q.push_back(exp_item(0));
    exp_q.push_back(exp_item(1));
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s1_arready, s0_arready} !== ((i == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL qos_tie_%0d: got ready %b", i, {s1_arready, s0_arready});
      end
      @(negedge clk);
    end
    tick();
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_arqos = 4'd0;
    s1_arqos = 4'd0;
    drain();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    rst_n = 1'b0;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_arqos = 4'd0;
    s1_arqos = 4'd0;
    m0_addr = '0; m0_len = '0; m0_size = '0; m0_burst = '0;
    m1_addr = '0; m1_len = '0; m1_size = '0; m1_burst = '0;
    sel_ready = 1'b0;
    r_done = 1'b0;
    r_done_id = 1'b0;

    test_reset();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_underflow();
    test_reset_in_send();
`ifdef AR_QOS_PRIORITY_EN
    test_qos();
`endif

    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending grants, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_channel_arbiter.md
AR_CHANNEL_ARBITER -- requirements
Module: ar_channel_arbiter

Interface
REQ-001 Parameter Masters_ID_Size, default 1, width of the granted-master ID; master count SHALL be 2 (M0, M1).
REQ-002 Parameter Address_width, default 32, ARADDR width.
REQ-003 Parameter AXI4_AR_len, default 8, ARLEN width.
REQ-004 Parameter Max_Outstanding, default 4, range 1..15, maximum accepted-but-uncompleted reads per master.
REQ-005 ACLK  in  1  sole clock, all state on rising edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 S0_AXI_arvalid/arqos/araddr/arlen/arsize/arburst  in  1/4/Address_width/AXI4_AR_len/3/2  master 0 AR request and payload.
REQ-008 S0_AXI_arready  out  1  master 0 AR acceptance.
REQ-009 S1_AXI_arvalid/arqos/araddr/arlen/arsize/arburst  in  as REQ-007  master 1 AR request and payload.
REQ-010 S1_AXI_arready  out  1  master 1 AR acceptance.
REQ-011 Master_AXI_araddr_ID/araddr/arlen/arsize/arburst/arvalid  out  Masters_ID_Size/Address_width/AXI4_AR_len/3/2/1  granted request toward the address decoder.
REQ-012 Sel_Slave_Ready  in  1  ARREADY of the decoded slave, returned by the decoder.
REQ-013 R_Done  in  1  one-cycle pulse: final read beat (RVALID&RREADY&RLAST) delivered.
REQ-014 R_Done_ID  in  Masters_ID_Size  master ID of the completed burst.
REQ-015 Err_Underflow  out  1  sticky: R_Done received for a master with zero outstanding.

Function
REQ-016 FSM SHALL have states IDLE and SEND.
REQ-017 Master k SHALL be eligible when Sk_AXI_arvalid=1 and outstanding[k] < Max_Outstanding.
REQ-018 In IDLE, S<k>_AXI_arready SHALL be 1 combinationally for exactly the arbitration winner, 0 otherwise; in SEND both SHALL be 0.
REQ-019 Arbitration SHALL be round-robin: the master not granted last wins when both are eligible; a single eligible master always wins.
REQ-020 On an IDLE handshake the winner's payload and ID SHALL be registered and the FSM SHALL enter SEND on the next edge.
REQ-021 In SEND, Master_AXI_arvalid SHALL be 1 and all Master_AXI_* outputs SHALL be held stable from the registers.
REQ-022 In SEND with Sel_Slave_Ready=1: handshake completes, outstanding[ID] increments, last-grant pointer updates to ID, FSM returns to IDLE.
REQ-023 Latency: Master_AXI_arvalid SHALL rise on the cycle after the master handshake; minimum issue interval 2 cycles.
REQ-024 R_Done SHALL decrement outstanding[R_Done_ID]; a same-cycle increment and decrement on one master SHALL leave the count unchanged.
REQ-025 R_Done with outstanding[R_Done_ID]=0 SHALL leave the count at 0 and set Err_Underflow until reset.
REQ-026 A master at Max_Outstanding SHALL be ineligible; the other master SHALL be granted without waiting.
REQ-027 Master_AXI_arvalid SHALL be 0 in IDLE; registered payload outputs SHALL hold their last values.

Reset
REQ-028 ARESETN low SHALL immediately force IDLE, counters 0, Err_Underflow 0, all Master_AXI_* outputs 0, and the last-grant pointer to M1 so M0 wins first.
REQ-029 Reset in SEND SHALL abandon the pending request with no counter update.

Configuration
REQ-030 With AR_QOS_PRIORITY_EN defined, the eligible master with strictly higher arqos SHALL win, with ties resolved by round-robin.
REQ-031 Without AR_QOS_PRIORITY_EN, arqos inputs SHALL be ignored and pure round-robin applies.

Verification
REQ-032 Both masters request continuously after reset, Sel_Slave_Ready=1 -> grants alternate M0,M1,M0,M1 with araddr_ID 0,1,0,1, each arvalid lasting 1 cycle.
REQ-033 M0 araddr=0x4000_0010, Sel_Slave_Ready held 0 for 5 cycles -> Master_AXI_arvalid=1 and araddr=0x4000_0010 stable 6 cycles, no arready to either master.
REQ-034 M0 issues 4 reads with no R_Done (Max_Outstanding=4) -> 5th M0 request stalls, M1 request is granted next; one R_Done with ID 0 -> M0 granted again.
REQ-035 R_Done with ID 1 when outstanding[1]=0 -> Err_Underflow=1 and stays 1; counts unchanged.
REQ-036 ARESETN pulsed low during SEND -> arvalid drops asynchronously, counters read 0, and the first post-reset grant goes to M0.
REQ-037 With AR_QOS_PRIORITY_EN, M0 arqos=2 and M1 arqos=9 both requesting -> M1 granted repeatedly; with equal arqos -> grants alternate.
